button_event_arbiter: RTL and testbench
=======================================

// Module: button_event_arbiter
// PURPOSE
//  Debounces NUM_INPUTS raw switches/buttons and turns debounced press edges into discrete events.
//  Round-robin arbitrates those events onto one valid/ready event port for a single consumer (UART, display, FSM).
//  Sits between board pins and user logic; also exposes the debounced levels.
// PARAMETERS
//  NUM_INPUTS      4       number of switch channels, >=2
//  DEBOUNCE_LIMIT  250000  consecutive cycles an input must differ from debounced state before the state flips, >=2
// PORTS
//  i_Clk           in   1           single clock; all logic on posedge
//  i_Rst           in   1           synchronous reset, active-high
//  i_Switch        in   NUM_INPUTS  raw asynchronous switch inputs
//  o_Switch        out  NUM_INPUTS  debounced levels
//  o_Event_Valid   out  1           event offered
//  i_Event_Ready   in   1           consumer accepts event when high with o_Event_Valid
//  o_Event_Id      out  ID_W        channel index of offered event; ID_W = max(1, $clog2(NUM_INPUTS))
//  o_Event_Press   out  1           1 = press (rising) event, 0 = release event
//  o_Overrun       out  1           sticky: an edge arrived while the same pending bit was still set
// BEHAVIOUR
//  Reset (i_Rst=1 at a clock edge): all outputs 0 on the next cycle; counters, pending bits and sync flops 0.
//   RR pointer r_Last = last index, so channel 0 wins first. Reset mid-offer drops the offered event.
//  Per channel: 2-FF synchronizer, then counter.
//   If sync input == state, counter <= 0.
//   Else if counter == DEBOUNCE_LIMIT-1: state <= input, counter <= 0.
//   Else counter++.
//  Latency: a stable input change reaches o_Switch DEBOUNCE_LIMIT+2 cycles later. Any glitch shorter than DEBOUNCE_LIMIT is invisible.
//  Edge detect: cycle after a debounced 0->1, press pending[i] <= 1.
//   If pending[i] is already 1 at that moment, o_Overrun <= 1 (cleared only by reset); event merged.
//  Arbiter FSM, 2 states:
//   IDLE: if any pending, pick first set request after r_Last (wrap-around). Latch id/type, clear that pending bit, go OFFER.
//    o_Event_Valid goes high the next cycle.
//   OFFER: o_Event_Valid=1; id/type held stable while i_Event_Ready=0.
//    On valid&&ready: r_Last <= granted index, go IDLE; o_Event_Valid=0 next cycle.
//   Throughput: max 1 event per 2 cycles. o_Event_Valid never drops without a handshake, except on reset.
//  Simultaneous edge-set and grant-clear of the same pending bit: set wins (new event retained, no overrun).
//  Request vector index k = 2*i + type (type 0 = press, 1 = release); RR is over k. ID_W width arithmetic never overflows.
// CONFIGURATION
//  `BUTTON_ARB_RELEASE_EVT_EN defined:
//   Debounced 1->0 edges set release pending bits with the same overrun rule.
//   Release events are arbitrated like presses; o_Event_Press=0 for them.
//  Not defined:
//   No release logic is built; only press requests exist (k = i); o_Event_Press is tied to 1.
// STRUCTURE
//  Package button_arb_pkg:
//   arbiter state encoding (ST_IDLE, ST_OFFER); event type constants EVT_PRESS, EVT_RELEASE;
//   ID width function.
//  Sub-module debounce_channel (synchronizer + counter + state, one bit), instantiated NUM_INPUTS times via generate.
//  Edge detect, pending/overrun registers and RR arbiter FSM live in the top.
// TESTING (bench with NUM_INPUTS=4, DEBOUNCE_LIMIT=4, i_Event_Ready=1 unless stated)
//  1 Bounce: i_Switch[0]=1 for 3 cycles then 0 -> o_Switch stays 0, no o_Event_Valid, o_Overrun=0.
//  2 Clean press: i_Switch[0] 0->1 at cycle t and held -> o_Switch[0]=1 at t+6; o_Event_Valid=1 at t+8, Id=0, Press=1; one cycle only.
//  3 Fairness: i_Switch[1] and [3] rise on the same cycle -> events Id=1 then Id=3;
//    then a new press on 0 and 1 together -> Id=0 first, then Id=1.
//  4 Backpressure/overrun: ready=0 while Id=2 offered; press 2 again and press 1 ->
//    Id=2 held stable all stall cycles, o_Overrun=1; after ready=1: Id=2, then Id=1, then Id=2 once; no further events.
//  5 Reset mid-offer: i_Rst=1 one cycle while o_Event_Valid=1 ->
//    next cycle o_Event_Valid=0, o_Switch=0, o_Overrun=0; next press on 0 yields Id=0.
//  6 Macro: press then release ch0.
//    With `BUTTON_ARB_RELEASE_EVT_EN: events (0,Press=1) then (0,Press=0).
//    Without: only (0,Press=1).

Source files
------------

// File: rtl/button_arb_pkg.sv
// rtl/button_arb_pkg.sv - arbiter state encoding, event type constants and id width helper
package button_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } arb_state_t;

    localparam logic EVT_PRESS   = 1'b0;
    localparam logic EVT_RELEASE = 1'b1;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one-bit 2-FF synchronizer plus consecutive-cycle debounce counter
module debounce_channel #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_Switch
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic             r_Sync1;
    logic             r_Sync2;
    logic             r_State;
    logic [CNT_W-1:0] r_Count;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Sync1 <= 1'b0;
            r_Sync2 <= 1'b0;
            r_State <= 1'b0;
            r_Count <= '0;
        end else begin
            r_Sync1 <= i_Switch;
            r_Sync2 <= r_Sync1;
            // Any cycle agreeing with the current state restarts the count.
            if (r_Sync2 == r_State) begin
                r_Count <= '0;
            end else if (r_Count == CNT_MAX) begin
                r_State <= r_Sync2;
                r_Count <= '0;
            end else begin
                r_Count <= r_Count + CNT_W'(1);
            end
        end
    end

    assign o_Switch = r_State;

endmodule

// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - debounced switch edges round-robin arbitrated onto one valid/ready port
// Optional release events: define BUTTON_ARB_RELEASE_EVT_EN.
module button_event_arbiter
    import button_arb_pkg::*;
#(
    parameter  int NUM_INPUTS     = 4,
    parameter  int DEBOUNCE_LIMIT = 250000,
    localparam int ID_W           = id_width(NUM_INPUTS)
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic [NUM_INPUTS-1:0] i_Switch,
    output logic [NUM_INPUTS-1:0] o_Switch,
    output logic                  o_Event_Valid,
    input  logic                  i_Event_Ready,
    output logic [ID_W-1:0]       o_Event_Id,
    output logic                  o_Event_Press,
    output logic                  o_Overrun
);

`ifdef BUTTON_ARB_RELEASE_EVT_EN
    localparam int NUM_REQ = 2 * NUM_INPUTS;
`else
    localparam int NUM_REQ = NUM_INPUTS;
`endif
    localparam int             K_W    = id_width(NUM_REQ);
    localparam logic [K_W-1:0] K_LAST = K_W'(NUM_REQ - 1);

    logic [NUM_INPUTS-1:0] w_Switch;
    logic [NUM_INPUTS-1:0] r_Switch_Prev;
    logic [NUM_REQ-1:0]    r_Pending;
    logic [NUM_REQ-1:0]    w_Set;
    logic [NUM_REQ-1:0]    w_Clear;
    logic [K_W-1:0]        r_Last;
    logic [K_W-1:0]        r_Grant;
    logic [K_W-1:0]        w_Pick;
    logic                  w_Any;
    logic                  w_Grant_En;
    logic                  r_Overrun;
    arb_state_t            r_State;
    arb_state_t            w_Next_State;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_chan
            debounce_channel #(
                .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
            ) u_debounce (
                .i_Clk   (i_Clk),
                .i_Rst   (i_Rst),
                .i_Switch(i_Switch[gi]),
                .o_Switch(w_Switch[gi])
            );
        end
    endgenerate

    // Request index k = 2*i + type when release events exist, else k = i.
    always_comb begin
        w_Set = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
`ifdef BUTTON_ARB_RELEASE_EVT_EN
            w_Set[2*i + int'(EVT_PRESS)]   = w_Switch[i] & ~r_Switch_Prev[i];
            w_Set[2*i + int'(EVT_RELEASE)] = ~w_Switch[i] & r_Switch_Prev[i];
`else
            w_Set[i] = w_Switch[i] & ~r_Switch_Prev[i];
`endif
        end
    end

    always_comb begin
        logic [K_W-1:0] idx;
        idx    = '0;
        w_Any  = 1'b0;
        w_Pick = r_Last;
        for (int s = 1; s <= NUM_REQ; s++) begin
            idx = K_W'((int'(r_Last) + s) % NUM_REQ);
            if (!w_Any && r_Pending[idx]) begin
                w_Any  = 1'b1;
                w_Pick = idx;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State <= ST_IDLE;
        end else begin
            r_State <= w_Next_State;
        end
    end

    always_comb begin
        w_Next_State  = r_State;
        w_Grant_En    = 1'b0;
        o_Event_Valid = 1'b0;
        case (r_State)
            ST_IDLE: begin
                if (w_Any) begin
                    w_Grant_En   = 1'b1;
                    w_Next_State = ST_OFFER;
                end
            end
            ST_OFFER: begin
                o_Event_Valid = 1'b1;
                if (i_Event_Ready) begin
                    w_Next_State = ST_IDLE;
                end
            end
        endcase
    end

    assign w_Clear = w_Grant_En ? (NUM_REQ'(1) << w_Pick) : '0;

    // A new edge wins over a same-cycle grant clear and is not an overrun.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Switch_Prev <= '0;
            r_Pending     <= '0;
            r_Overrun     <= 1'b0;
            r_Last        <= K_LAST;
            r_Grant       <= '0;
        end else begin
            r_Switch_Prev <= w_Switch;
            r_Pending     <= (r_Pending & ~w_Clear) | w_Set;
            if (|(w_Set & r_Pending & ~w_Clear)) begin
                r_Overrun <= 1'b1;
            end
            if (w_Grant_En) begin
                r_Grant <= w_Pick;
            end
            if ((r_State == ST_OFFER) && i_Event_Ready) begin
                r_Last <= r_Grant;
            end
        end
    end

`ifdef BUTTON_ARB_RELEASE_EVT_EN
    assign o_Event_Id    = ID_W'(r_Grant >> 1);
    assign o_Event_Press = (r_State == ST_OFFER) && (r_Grant[0] == EVT_PRESS);
`else
    assign o_Event_Id    = ID_W'(r_Grant);
    assign o_Event_Press = 1'b1;
`endif

    assign o_Switch  = w_Switch;
    assign o_Overrun = r_Overrun;

endmodule

// File: tb/tb_button_event_arbiter.sv
// tb/tb_button_event_arbiter.sv - directed and randomized checks of button_event_arbiter against a reference model
module tb_button_event_arbiter;

    localparam int N    = 4;
    localparam int L    = 4;
    localparam int ID_W = 2;
`ifdef BUTTON_ARB_RELEASE_EVT_EN
    localparam int NK  = 2 * N;
    localparam bit REL = 1'b1;
`else
    localparam int NK  = N;
    localparam bit REL = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            i_Rst = 1'b0;
    logic [N-1:0]    i_Switch = '0;
    logic            i_Event_Ready = 1'b1;
    logic [N-1:0]    o_Switch;
    logic            o_Event_Valid;
    logic [ID_W-1:0] o_Event_Id;
    logic            o_Event_Press;
    logic            o_Overrun;

    always #5 clk = ~clk;

    button_event_arbiter #(
        .NUM_INPUTS    (N),
        .DEBOUNCE_LIMIT(L)
    ) dut (
        .i_Clk        (clk),
        .i_Rst        (i_Rst),
        .i_Switch     (i_Switch),
        .o_Switch     (o_Switch),
        .o_Event_Valid(o_Event_Valid),
        .i_Event_Ready(i_Event_Ready),
        .o_Event_Id   (o_Event_Id),
        .o_Event_Press(o_Event_Press),
        .o_Overrun    (o_Overrun)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_valid_seen = 0;
    logic [ID_W:0] ev_log[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    endtask

    // Reference model: a level flips once the synchronized input has disagreed with it
    // for the last L samples; events are a set of pending requests served round-robin.
    logic [N-1:0]  rawq[$];
    logic [N-1:0]  winq[$];
    logic [N-1:0]  m_sw, m_rise, m_fall;
    logic [NK-1:0] m_pend;
    int            m_last, m_k;
    bit            m_offer, m_ovr, m_live = 1'b0;

    always @(posedge clk) begin : p_model
        logic [N-1:0]  sync_v, new_sw;
        logic [NK-1:0] set_v, clr_v;
        bit            flip, found;
        int            k;
        if (i_Rst) begin
            rawq.delete();
            repeat (3) rawq.push_back('0);
            winq.delete();
            m_sw = '0; m_rise = '0; m_fall = '0; m_pend = '0;
            m_last = NK - 1; m_k = 0; m_offer = 1'b0; m_ovr = 1'b0; m_live = 1'b1;
        end else if (m_live) begin
            rawq.push_front(i_Switch);
            sync_v = rawq[2];
            while (rawq.size() > 3) void'(rawq.pop_back());
            winq.push_front(sync_v);
            while (winq.size() > L) void'(winq.pop_back());
            new_sw = m_sw;
            if (winq.size() == L) begin
                for (int i = 0; i < N; i++) begin
                    flip = 1'b1;
                    foreach (winq[j]) if (winq[j][i] == m_sw[i]) flip = 1'b0;
                    if (flip) new_sw[i] = ~m_sw[i];
                end
            end
            clr_v = '0;
            if (m_offer) begin
                if (i_Event_Ready) begin
                    m_last  = m_k;
                    m_offer = 1'b0;
                end
            end else if (m_pend != '0) begin
                found = 1'b0;
                for (int s = 1; s <= NK; s++) begin
                    k = (m_last + s) % NK;
                    if (!found && m_pend[k]) begin
                        found = 1'b1;
                        m_k   = k;
                    end
                end
                clr_v[m_k] = 1'b1;
                m_offer    = 1'b1;
            end
            set_v = '0;
            for (int i = 0; i < N; i++) begin
`ifdef BUTTON_ARB_RELEASE_EVT_EN
                set_v[2*i]   = m_rise[i];
                set_v[2*i+1] = m_fall[i];
`else
                set_v[i] = m_rise[i];
`endif
            end
            for (int q = 0; q < NK; q++) begin
                if (set_v[q] && m_pend[q] && !clr_v[q]) m_ovr = 1'b1;
                if (clr_v[q]) m_pend[q] = 1'b0;
                if (set_v[q]) m_pend[q] = 1'b1;
            end
            m_rise = new_sw & ~m_sw;
            m_fall = ~new_sw & m_sw;
            m_sw   = new_sw;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check_eq("switch", o_Switch, m_sw);
            check_eq("valid", o_Event_Valid, m_offer);
            check_eq("overrun", o_Overrun, m_ovr);
            if (m_offer) begin
                check_eq("id", o_Event_Id, REL ? m_k / 2 : m_k);
                check_eq("press", o_Event_Press, REL ? ((m_k % 2) == 0) : 1);
            end
            if (o_Event_Valid) n_valid_seen++;
            if (o_Event_Valid && i_Event_Ready && !i_Rst) ev_log.push_back({o_Event_Id, o_Event_Press});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        i_Rst    = 1'b1;
        i_Switch = '0;
        tick(1);
        i_Rst = 1'b0;
        check_eq("rst_valid", o_Event_Valid, 0);
        check_eq("rst_switch", o_Switch, 0);
        check_eq("rst_overrun", o_Overrun, 0);
        n_valid_seen = 0;
        ev_log.delete();
    endtask

    task automatic wait_valid(input string tag, input int max);
        int c = 0;
        while (!o_Event_Valid && c < max) begin
            tick(1);
            c++;
        end
        check_eq(tag, o_Event_Valid, 1);
    endtask

    task automatic stall(input int n);
        repeat (n) begin
            tick(1);
            check_eq("stall_valid", o_Event_Valid, 1);
            check_eq("stall_id", o_Event_Id, 2);
        end
    endtask

    // Expected entries are encoded id*2 + press.
    task automatic check_log(input string tag, input int n, input int e0, input int e1, input int e2, input int e3);
        int want[4];
        want = '{e0, e1, e2, e3};
        check_eq({tag, "_count"}, ev_log.size(), n);
        for (int j = 0; j < n && j < ev_log.size(); j++)
            check_eq($sformatf("%s_ev%0d", tag, j), 32'(ev_log[j]), want[j]);
    endtask

    initial begin
        tick(1);
        do_reset();

        i_Switch[0] = 1'b1;
        tick(3);
        i_Switch[0] = 1'b0;
        tick(12);
        check_eq("bounce_switch", o_Switch, 0);
        check_eq("bounce_events", n_valid_seen, 0);
        check_eq("bounce_overrun", o_Overrun, 0);

        i_Switch[0] = 1'b1;
        tick(5);
        check_eq("press_sw_early", o_Switch[0], 0);
        tick(1);
        check_eq("press_sw_t6", o_Switch[0], 1);
        tick(1);
        check_eq("press_valid_t7", o_Event_Valid, 0);
        tick(1);
        check_eq("press_valid_t8", o_Event_Valid, 1);
        check_eq("press_id_t8", o_Event_Id, 0);
        check_eq("press_type_t8", o_Event_Press, 1);
        tick(1);
        check_eq("press_valid_t9", o_Event_Valid, 0);

        do_reset();
        i_Switch = 4'b1010;
        tick(20);
        check_log("fair1", 2, 3, 7, 0, 0);
        i_Switch = 4'b0000;
        tick(20);
        ev_log.delete();
        i_Switch = 4'b0011;
        tick(20);
        check_log("fair2", 2, 1, 3, 0, 0);

        do_reset();
        i_Event_Ready = 1'b0;
        i_Switch[2]   = 1'b1;
        wait_valid("stall_offer", 20);
        check_eq("stall_first_id", o_Event_Id, 2);
        i_Switch[1] = 1'b1;
        i_Switch[2] = 1'b0;
        stall(8);
        i_Switch[2] = 1'b1;
        stall(8);
        i_Switch[2] = 1'b0;
        stall(8);
        i_Switch[2] = 1'b1;
        stall(10);
        check_eq("stall_overrun", o_Overrun, 1);
        i_Event_Ready = 1'b1;
        tick(20);
        if (REL) check_log("backpressure", 4, 5, 4, 3, 5);
        else     check_log("backpressure", 3, 5, 3, 5, 0);

        i_Event_Ready = 1'b0;
        i_Switch[0]   = 1'b1;
        wait_valid("midoffer_offer", 20);
        i_Rst    = 1'b1;
        i_Switch = '0;
        tick(1);
        i_Rst = 1'b0;
        check_eq("midoffer_valid", o_Event_Valid, 0);
        check_eq("midoffer_switch", o_Switch, 0);
        check_eq("midoffer_overrun", o_Overrun, 0);
        ev_log.delete();
        i_Event_Ready = 1'b1;
        i_Switch[0]   = 1'b1;
        tick(20);
        check_log("after_reset", 1, 1, 0, 0, 0);

        do_reset();
        i_Switch[0] = 1'b1;
        tick(20);
        i_Switch[0] = 1'b0;
        tick(20);
        if (REL) check_log("press_release", 2, 1, 0, 0, 0);
        else     check_log("press_release", 1, 1, 0, 0, 0);

        do_reset();
        repeat (3000) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 15) == 0) i_Switch[c] = ~i_Switch[c];
            i_Event_Ready = ($urandom_range(0, 3) != 0);
            i_Rst         = ($urandom_range(0, 599) == 0);
            tick(1);
        end
        i_Rst = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
